// File: rtl/prbs_pkg.sv
// Shared constants and types for the PRBS9 receive checker.
// Polynomial x^9 + x^5 + 1: s[n] = s[n-5] ^ s[n-9], so with the newest bit at
// hist[0] the taps sit at hist[4] and hist[8].
package prbs_pkg;

  localparam int PRBS_LEN   = 9;
  localparam int PRBS_TAP_A = 4;
  localparam int PRBS_TAP_B = 8;

  // Default lock-loss window and the width of counters that index it
  localparam int LOSS_WINDOW_DEF = 64;
  localparam int WIN_W_DEF       = $clog2(LOSS_WINDOW_DEF);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Per-bit count request handed to the two event counters
  typedef struct packed {
    logic inc_bit;
    logic inc_err;
  } cnt_req_t;

  // Width of a counter that walks 0..window-1 (never narrower than 1 bit)
  function automatic int win_w(input int window);
    return (window < 2) ? 1 : $clog2(window);
  endfunction

endpackage

// File: rtl/prbs_event_counter.sv
// Event counter for the PRBS checker statistics.
// Synchronous clear beats a coincident increment.
// Build option PRBS_CHECKER_SAT_EN: saturate at all-ones instead of wrapping.
module prbs_event_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // Count events; clear has priority, overflow behaviour chosen at build time
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
`ifdef PRBS_CHECKER_SAT_EN
      if (count != '1) count <= count + ONE;
`else
      count <= count + ONE;
`endif
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// PRBS9 receive checker: self-synchronises to the incoming stream, then
// free-runs a local reference LFSR and counts checked bits and bit errors.
// Too many errors inside one observation window drops back to hunting.
// Build option PRBS_CHECKER_SAT_EN: statistics counters saturate instead of wrap.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_COUNT  = 16,
  parameter int LOSS_WINDOW = LOSS_WINDOW_DEF,
  parameter int LOSS_THRESH = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             bit_in,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int WIN_W   = win_w(LOSS_WINDOW);
  localparam int WERR_W  = $clog2(LOSS_THRESH + 1);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int FILL_W  = $clog2(PRBS_LEN + 1);

  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PRBS_LEN);
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(LOSS_WINDOW - 1);
  localparam logic [WERR_W-1:0]  WERR_LIM  = WERR_W'(LOSS_THRESH);

  state_t              state, state_n;
  logic [PRBS_LEN-1:0] hist, hist_n;
  logic [FILL_W-1:0]   fill, fill_n;
  logic [MATCH_W-1:0]  match_cnt, match_n;
  logic [WIN_W-1:0]    win_cnt, win_cnt_n;
  logic [WERR_W-1:0]   win_err, win_err_n;
  logic                pulse_n;
  logic                pred, err;
  cnt_req_t            req;

  assign pred   = hist[PRBS_TAP_A] ^ hist[PRBS_TAP_B];
  assign err    = bit_in ^ pred;
  assign locked = (state == LOCKED);

  // Sync/lock state, history and window registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= HUNT;
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_n;
      hist      <= hist_n;
      fill      <= fill_n;
      match_cnt <= match_n;
      win_cnt   <= win_cnt_n;
      win_err   <= win_err_n;
      err_pulse <= pulse_n;
    end
  end

  // Next-state: hunt on received bits, then check against the local LFSR
  always_comb begin
    state_n   = state;
    hist_n    = hist;
    fill_n    = fill;
    match_n   = match_cnt;
    win_cnt_n = win_cnt;
    win_err_n = win_err;
    pulse_n   = 1'b0;
    req       = '0;
    if (enable) begin
      case (state)
        HUNT: begin
          hist_n = {hist[PRBS_LEN-2:0], bit_in};
          if (fill != FILL_FULL) fill_n = fill + FILL_W'(1);
          if (fill == FILL_FULL) begin
            // All-zero history trivially satisfies the recurrence; never count it
            if (hist == '0) begin
              match_n = '0;
            end else if (bit_in == pred) begin
              if (match_cnt == MATCH_MAX) begin
                state_n = LOCKED;
                match_n = '0;
              end else begin
                match_n = match_cnt + MATCH_W'(1);
              end
            end else begin
              match_n = '0;
            end
          end
        end
        LOCKED: begin
          // Reference runs on its own prediction so a bad bit is counted once
          hist_n      = {hist[PRBS_LEN-2:0], pred};
          pulse_n     = err;
          req.inc_bit = 1'b1;
          req.inc_err = err;
          if (win_cnt == WIN_LAST) begin
            win_cnt_n = '0;
            win_err_n = WERR_W'(err);
          end else begin
            win_cnt_n = win_cnt + WIN_W'(1);
            win_err_n = win_err + WERR_W'(err);
          end
          if (win_err_n >= WERR_LIM) begin
            state_n   = HUNT;
            hist_n    = '0;
            fill_n    = '0;
            match_n   = '0;
            win_cnt_n = '0;
            win_err_n = '0;
          end
        end
        default: ;
      endcase
    end
  end

  prbs_event_counter #(.CNT_W(CNT_W)) u_bit_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (req.inc_bit),
    .count (bit_count)
  );

  prbs_event_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (req.inc_err),
    .count (err_count)
  );

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: PRBS9 source, sequence-level reference model,
// directed scenarios plus a randomized error/enable/clear run.
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        bit_in = 1'b0;
  logic        clear = 1'b0;
  logic        locked, err_pulse;
  logic [31:0] bit_count, err_count;
  logic        locked2, err_pulse2;
  logic [3:0]  bit_count2, err_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prbs_checker #(.LOCK_COUNT(16), .LOSS_WINDOW(64), .LOSS_THRESH(8), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bit_in(bit_in), .clear(clear),
    .locked(locked), .err_pulse(err_pulse), .bit_count(bit_count), .err_count(err_count)
  );

  // Narrow, high-threshold instance for counter overflow behaviour
  prbs_checker #(.LOCK_COUNT(16), .LOSS_WINDOW(64), .LOSS_THRESH(64), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .bit_in(bit_in), .clear(clear),
    .locked(locked2), .err_pulse(err_pulse2), .bit_count(bit_count2), .err_count(err_count2)
  );

  // ---------------- PRBS9 source: s[n] = s[n-5] ^ s[n-9] ----------------
  bit gen_q[$];

  task automatic gen_seed();
    gen_q = {};
    for (int i = 0; i < 9; i++) gen_q.push_back(1'b1);  // seed 9'h1FF
  endtask

  task automatic gen_bit(output bit b);
    b = gen_q[$-4] ^ gen_q[$-8];
    gen_q.push_back(b);
    if (gen_q.size() > 16) void'(gen_q.pop_front());
  endtask

  // ---------------- reference model (sequence level) ----------------
  bit          m_locked;
  bit          m_pulse;
  bit          m_rx[$];     // last received bits while hunting
  bit          m_ref[$];    // expected sequence while locked
  int          m_run;       // consecutive recurrence matches
  int          m_k;         // bits checked since lock
  int          m_grp, m_grp_err;
  logic [31:0] m_bits, m_errs;

  task automatic model_reset();
    m_locked = 0; m_pulse = 0; m_rx = {}; m_ref = {};
    m_run = 0; m_k = 0; m_grp = 0; m_grp_err = 0; m_bits = 0; m_errs = 0;
  endtask

  task automatic model_step(input bit en, input bit b, input bit clr);
    bit e, expb, allz;
    int grp;
    e = 0;
    if (en) begin
      if (!m_locked) begin
        if (m_rx.size() >= 9) begin
          allz = 1;
          foreach (m_rx[i]) if (m_rx[i]) allz = 0;
          if (allz) m_run = 0;
          else if (b == (m_rx[$-4] ^ m_rx[$-8])) m_run++;
          else m_run = 0;
        end
        m_rx.push_back(b);
        if (m_rx.size() > 9) void'(m_rx.pop_front());
        if (m_run == 16) begin
          m_locked = 1; m_ref = m_rx; m_run = 0;
          m_k = 0; m_grp = 0; m_grp_err = 0;
        end
      end else begin
        expb = m_ref[$-4] ^ m_ref[$-8];
        m_ref.push_back(expb);
        void'(m_ref.pop_front());
        e = (b != expb);
        m_bits = m_bits + 32'd1;
        m_errs = m_errs + {31'd0, e};
        // Windows: first spans bits 0..62 after lock, then every 64 bits
        grp = (m_k + 1) / 64;
        if (grp != m_grp) begin m_grp = grp; m_grp_err = 0; end
        m_grp_err += int'(e);
        m_k++;
        if (m_grp_err >= 8) begin m_locked = 0; m_rx = {}; m_run = 0; end
      end
    end
    if (clr) begin m_bits = 0; m_errs = 0; end
    m_pulse = e;
  endtask

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge
  task automatic step(input bit en, input bit b, input bit clr);
    enable = en; bit_in = b; clear = clr;
    @(posedge clk);
    model_step(en, b, clr);
    #1;
  endtask

  task automatic do_reset();
    enable = 0; bit_in = 0; clear = 0;
    reset = 1;
    model_reset();
    gen_seed();
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic lock_up();
    bit b;
    for (int i = 0; i < 25; i++) begin gen_bit(b); step(1, b, 0); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bit b;
    do_reset();
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b expected 0", err_pulse); end
    checks++; if (bit_count !== 32'd0 || err_count !== 32'd0) begin errors++;
      $display("FAIL reset_counts: got %0d/%0d expected 0/0", bit_count, err_count); end
    // Asynchronous reset mid-operation, sampled before any further clock edge
    lock_up();
    for (int i = 0; i < 10; i++) begin gen_bit(b); step(1, b, 0); end
    #2 reset = 1;
    #1;
    checks++; if (locked !== 1'b0 || bit_count !== 32'd0) begin errors++;
      $display("FAIL async_reset: got locked=%b bits=%0d expected 0/0", locked, bit_count); end
    do_reset();
    for (int i = 0; i < 24; i++) begin gen_bit(b); step(1, b, 0); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL relock_early: got %b expected 0", locked); end
    gen_bit(b); step(1, b, 0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock_25: got %b expected 1", locked); end
  endtask

  task automatic test_clean_lock();
    bit b;
    int pulses;
    do_reset();
    for (int i = 1; i <= 25; i++) begin
      gen_bit(b); step(1, b, 0);
      if (i == 24) begin checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_at_24: got %b expected 0", locked); end end
      if (i == 25) begin checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_at_25: got %b expected 1", locked); end end
    end
    pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      gen_bit(b); step(1, b, 0);
      if (err_pulse) pulses++;
      checks++;
      if ({locked, err_pulse, bit_count, err_count} !== {m_locked, m_pulse, m_bits, m_errs}) begin errors++;
        $display("FAIL clean_cycle%0d: got l=%b p=%b b=%0d e=%0d expected l=%b p=%b b=%0d e=%0d", i,
                 locked, err_pulse, bit_count, err_count, m_locked, m_pulse, m_bits, m_errs); end
    end
    checks++; if (bit_count !== 32'd1000) begin errors++; $display("FAIL clean_bits: got %0d expected 1000", bit_count); end
    checks++; if (err_count !== 32'd0) begin errors++; $display("FAIL clean_errs: got %0d expected 0", err_count); end
    checks++; if (pulses != 0) begin errors++; $display("FAIL clean_pulses: got %0d expected 0", pulses); end
  endtask

  // Continues from the locked state left by test_clean_lock
  task automatic test_single_error();
    bit b;
    int pulses;
    gen_bit(b); step(1, ~b, 0);
    pulses = err_pulse ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      gen_bit(b); step(1, b, 0);
      if (err_pulse) pulses++;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL single_pulses: got %0d expected 1", pulses); end
    checks++; if (err_count !== 32'd1) begin errors++; $display("FAIL single_errs: got %0d expected 1", err_count); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL single_locked: got %b expected 1", locked); end
    checks++; if (bit_count !== 32'd1101) begin errors++; $display("FAIL single_bits: got %0d expected 1101", bit_count); end
  endtask

  task automatic test_zero_stream();
    int ever_locked;
    do_reset();
    ever_locked = 0;
    for (int i = 0; i < 500; i++) begin
      step(1, 1'b0, 0);
      if (locked) ever_locked++;
    end
    checks++; if (ever_locked != 0) begin errors++; $display("FAIL zero_locked: got %0d locked cycles expected 0", ever_locked); end
    checks++; if (bit_count !== 32'd0 || err_count !== 32'd0) begin errors++;
      $display("FAIL zero_counts: got %0d/%0d expected 0/0", bit_count, err_count); end
  endtask

  task automatic test_lock_loss();
    bit b;
    int n;
    do_reset();
    lock_up();
    // 8 errors on even positions 0..14: 15 enables in total
    for (int i = 0; i <= 14; i++) begin
      gen_bit(b);
      step(1, (i % 2 == 0) ? ~b : b, 0);
      if (i < 14) begin
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL loss_early%0d: got %b expected 1", i, locked); end
      end
    end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL loss_drop: got %b expected 0", locked); end
    checks++; if (err_count !== 32'd8) begin errors++; $display("FAIL loss_errs: got %0d expected 8", err_count); end
    n = 0;
    while (!locked && n < 40) begin gen_bit(b); step(1, b, 0); n++; end
    checks++; if (!locked || n > 25) begin errors++; $display("FAIL loss_relock: got %0d enables expected <= 25", n); end
  endtask

  task automatic test_clear_collision();
    bit b;
    do_reset();
    lock_up();
    for (int i = 1; i <= 40; i++) begin
      gen_bit(b);
      step(1, (i == 10 || i == 20 || i == 30) ? ~b : b, 0);
    end
    checks++; if (bit_count !== 32'd40 || err_count !== 32'd3) begin errors++;
      $display("FAIL coll_pre: got %0d/%0d expected 40/3", bit_count, err_count); end
    gen_bit(b); step(1, ~b, 1);
    checks++; if (bit_count !== 32'd0 || err_count !== 32'd0) begin errors++;
      $display("FAIL coll_counts: got %0d/%0d expected 0/0", bit_count, err_count); end
    checks++; if (err_pulse !== 1'b1 || locked !== 1'b1) begin errors++;
      $display("FAIL coll_pulse_lock: got p=%b l=%b expected 1/1", err_pulse, locked); end
    gen_bit(b); step(1, b, 0);
    checks++; if (err_pulse !== 1'b0 || bit_count !== 32'd1) begin errors++;
      $display("FAIL coll_after: got p=%b b=%0d expected 0/1", err_pulse, bit_count); end
  endtask

  // Continues locked from test_clear_collision
  task automatic test_enable_gap();
    bit b;
    logic [31:0] bc, ec;
    gen_bit(b); step(1, ~b, 0);
    bc = bit_count; ec = err_count;
    for (int i = 0; i < 5; i++) begin
      step(0, 1'($urandom_range(0, 1)), 0);
      checks++;
      if (err_pulse !== 1'b0 || locked !== 1'b1 || bit_count !== bc || err_count !== ec) begin errors++;
        $display("FAIL gap_hold%0d: got p=%b l=%b b=%0d e=%0d expected 0/1/%0d/%0d", i,
                 err_pulse, locked, bit_count, err_count, bc, ec); end
    end
    for (int i = 0; i < 20; i++) begin gen_bit(b); step(1, b, 0); end
    checks++; if (err_count !== ec || bit_count !== bc + 32'd20) begin errors++;
      $display("FAIL gap_resume: got %0d/%0d expected %0d/%0d", bit_count, err_count, bc + 32'd20, ec); end
  endtask

  task automatic test_random();
    bit b, en, clr, inj;
    int rate, lock_cycles;
    do_reset();
    lock_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      rate = ((i / 400) % 2 == 1) ? 20 : 1;  // alternate quiet and noisy phases
      en  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 199) == 0);
      inj = ($urandom_range(0, 99) < rate);
      b = 1'($urandom_range(0, 1));
      if (en) begin gen_bit(b); if (inj) b = ~b; end
      step(en, b, clr);
      if (m_locked) lock_cycles++;
      checks++;
      if ({locked, err_pulse, bit_count, err_count} !== {m_locked, m_pulse, m_bits, m_errs}) begin errors++;
        $display("FAIL rand_cycle%0d: got l=%b p=%b b=%0d e=%0d expected l=%b p=%b b=%0d e=%0d", i,
                 locked, err_pulse, bit_count, err_count, m_locked, m_pulse, m_bits, m_errs); end
    end
    checks++; if (lock_cycles == 0) begin errors++; $display("FAIL rand_coverage: got 0 locked cycles expected > 0"); end
  endtask

  task automatic test_saturation();
    bit b;
    logic [3:0] exp_e, exp_b;
`ifdef PRBS_CHECKER_SAT_EN
    exp_e = 4'd15; exp_b = 4'd15;
`else
    exp_e = 4'd4;  exp_b = 4'd8;   // 20 mod 16, 40 mod 16
`endif
    do_reset();
    lock_up();
    for (int i = 0; i < 40; i++) begin gen_bit(b); step(1, (i % 2 == 1) ? ~b : b, 0); end
    checks++; if (locked2 !== 1'b1) begin errors++; $display("FAIL sat_locked: got %b expected 1", locked2); end
    checks++; if (err_count2 !== exp_e) begin errors++; $display("FAIL sat_errs: got %0d expected %0d", err_count2, exp_e); end
    checks++; if (bit_count2 !== exp_b) begin errors++; $display("FAIL sat_bits: got %0d expected %0d", bit_count2, exp_b); end
    gen_bit(b); step(0, b, 1);
    checks++; if (err_count2 !== 4'd0 || bit_count2 !== 4'd0) begin errors++;
      $display("FAIL sat_clear: got %0d/%0d expected 0/0", bit_count2, err_count2); end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_single_error();
    test_zero_stream();
    test_lock_loss();
    test_clear_collision();
    test_enable_gap();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
